// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the sequential floating-point multiplier.
//   state_t       : FSM encoding (IDLE, MUL, NORM, DONE)
//   FLAG_*        : bit positions inside the 4-bit exception flag vector
//   bias_of       : exponent bias for a given exponent width
//   exp_max_of    : all-ones exponent (inf/NaN code) for a given exponent width
//   qnan_bits     : canonical quiet NaN pattern (sign 0, exp all ones, frac MSB 1)
//   BIAS, EXP_MAX : values for the default single-precision format
package fp_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  function automatic int bias_of(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int exp_max_of(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

  localparam int DEF_EXP_W = 8;
  localparam int BIAS      = bias_of(DEF_EXP_W);
  localparam int EXP_MAX   = exp_max_of(DEF_EXP_W);

  // Returned 64 bits wide; callers keep the low 1+exp_w+frac_w bits.
  function automatic logic [63:0] qnan_bits(input int exp_w, input int frac_w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < exp_w; i++) r[frac_w + i] = 1'b1;
    r[frac_w - 1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/fp_round_norm.sv
// Combinational normalise / round-to-nearest-even / range check stage.
//   prod    : raw significand product, 2*(FRAC_W+1) bits, value in [1,4)
//   exp_sum : e1 + e2 - bias, signed, EXP_W+2 bits
//   sign    : result sign
//   result  : packed {sign, exponent, fraction}
//   flags   : {invalid, overflow, underflow, inexact}; invalid is always 0 here
module fp_round_norm
  import fp_mul_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic [2*FRAC_W+1:0]     prod,
  input  logic signed [EXP_W+1:0] exp_sum,
  input  logic                    sign,
  output logic [EXP_W+FRAC_W:0]   result,
  output logic [3:0]              flags
);

  localparam int PROD_W = 2 * (FRAC_W + 1);
  localparam int EXT_W  = EXP_W + 2;
  localparam logic signed [EXT_W-1:0] EMAX_S = EXT_W'(exp_max_of(EXP_W));

  logic                    norm;
  logic [PROD_W-2:0]       pn;
  logic [FRAC_W-1:0]       frac;
  logic                    guard;
  logic                    sticky;
  logic                    round_up;
  logic [FRAC_W:0]         frac_r;
  logic                    carry;
  logic signed [EXT_W-1:0] e_fin;

  always_comb begin
    // Align so the leading one sits just above pn's top bit; the bit below
    // the kept fraction is the guard, everything under it folds into sticky.
    norm     = prod[PROD_W-1];
    pn       = norm ? prod[PROD_W-2:0] : {prod[PROD_W-3:0], 1'b0};
    frac     = pn[PROD_W-2 -: FRAC_W];
    guard    = pn[PROD_W-2-FRAC_W];
    sticky   = |pn[PROD_W-3-FRAC_W:0];
    round_up = guard & (sticky | frac[0]);
    frac_r   = {1'b0, frac} + (FRAC_W+1)'(round_up);
    // A carry out of the fraction means 1.11..1 rounded to 10.0: the
    // fraction field is already zero, only the exponent moves.
    carry    = frac_r[FRAC_W];
    e_fin    = exp_sum + $signed({{(EXT_W-1){1'b0}}, norm})
                       + $signed({{(EXT_W-1){1'b0}}, carry});

    flags = 4'b0000;
    flags[FLAG_INEXACT] = guard | sticky;
    result = {sign, e_fin[EXP_W-1:0], frac_r[FRAC_W-1:0]};

    if (e_fin >= EMAX_S) begin
      result = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      flags[FLAG_OVERFLOW] = 1'b1;
      flags[FLAG_INEXACT]  = 1'b1;
    end else if (e_fin <= 0) begin
      // No subnormal outputs: anything below the normal range flushes.
      result = {sign, {(EXP_W+FRAC_W){1'b0}}};
      flags[FLAG_UNDERFLOW] = 1'b1;
      flags[FLAG_INEXACT]   = 1'b1;
    end
  end

endmodule

// File: rtl/fp_mul_seq.sv
// Sequential IEEE-754 multiplier with valid/ready on both sides.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake
//   in1, in2            : operands {sign, exponent, fraction}
//   out_valid/out_ready : result handshake
//   out, flags          : product and {invalid, overflow, underflow, inexact}
//   dbg_state           : current FSM state
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE,
// where out and flags are held until the transfer. No same-cycle bypass from
// DONE back to accepting new operands.
module fp_mul_seq
  import fp_mul_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int BPC    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+FRAC_W:0]  in1,
  input  logic [EXP_W+FRAC_W:0]  in2,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+FRAC_W:0]  out,
  output logic [3:0]             flags,
  output state_t                 dbg_state
);

  localparam int W      = 1 + EXP_W + FRAC_W;
  localparam int SIG_W  = FRAC_W + 1;
  localparam int PROD_W = 2 * SIG_W;
  localparam int N      = SIG_W / BPC;
  localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;
  localparam int EXT_W  = EXP_W + 2;
  localparam int EBIAS  = bias_of(EXP_W);
  localparam logic [63:0]  QNAN64 = qnan_bits(EXP_W, FRAC_W);
  localparam logic [W-1:0] QNAN   = QNAN64[W-1:0];

  state_t              state;
  logic                sign_r;
  logic [EXP_W-1:0]    e1_r;
  logic [EXP_W-1:0]    e2_r;
  logic [PROD_W-1:0]   mc;     // multiplicand, shifted left BPC per cycle
  logic [SIG_W-1:0]    mb;     // multiplier, shifted right BPC per cycle
  logic [PROD_W-1:0]   acc;
  logic [CNT_W-1:0]    cnt;
  logic [W-1:0]        out_r;
  logic [3:0]          flags_r;

  // Operand fields
  logic                sa, sb;
  logic [EXP_W-1:0]    ea, eb;
  logic [FRAC_W-1:0]   fa, fb;

  assign sa = in1[W-1];
  assign sb = in2[W-1];
  assign ea = in1[FRAC_W +: EXP_W];
  assign eb = in2[FRAC_W +: EXP_W];
  assign fa = in1[FRAC_W-1:0];
  assign fb = in2[FRAC_W-1:0];

  // Classification. A zero exponent covers both true zero and subnormals,
  // which are flushed to zero without raising underflow.
  logic a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
  logic s_res;
  logic          spec_hit;
  logic [W-1:0]  spec_out;
  logic [3:0]    spec_flags;

  always_comb begin
    a_nan  = (&ea) && (fa != '0);
    b_nan  = (&eb) && (fb != '0);
    a_snan = a_nan && !fa[FRAC_W-1];
    b_snan = b_nan && !fb[FRAC_W-1];
    a_inf  = (&ea) && (fa == '0);
    b_inf  = (&eb) && (fb == '0);
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    s_res  = sa ^ sb;

    spec_hit   = 1'b1;
    spec_out   = '0;
    spec_flags = 4'b0000;
    if (a_nan || b_nan) begin
      spec_out = QNAN;
      spec_flags[FLAG_INVALID] = a_snan | b_snan;
    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
      spec_out = QNAN;
      spec_flags[FLAG_INVALID] = 1'b1;
    end else if (a_inf || b_inf) begin
      spec_out = {s_res, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end else if (a_zero || b_zero) begin
      spec_out = {s_res, {(W-1){1'b0}}};
    end else begin
      spec_hit = 1'b0;
    end
  end

  // BPC partial products for this MUL cycle.
  logic [PROD_W-1:0] pp_sum;

  always_comb begin
    pp_sum = acc;
    for (int j = 0; j < BPC; j++) begin
      if (mb[j]) pp_sum = pp_sum + (mc << j);
    end
  end

  // Normalise/round stage, sampled in NORM.
  logic signed [EXT_W-1:0] exp_sum;
  logic [W-1:0]            rn_result;
  logic [3:0]              rn_flags;

  assign exp_sum = {2'b00, e1_r} + {2'b00, e2_r} - EXT_W'(EBIAS);

  fp_round_norm #(
    .EXP_W  (EXP_W),
    .FRAC_W (FRAC_W)
  ) u_round_norm (
    .prod    (acc),
    .exp_sum (exp_sum),
    .sign    (sign_r),
    .result  (rn_result),
    .flags   (rn_flags)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sign_r  <= 1'b0;
      e1_r    <= '0;
      e2_r    <= '0;
      mc      <= '0;
      mb      <= '0;
      acc     <= '0;
      cnt     <= '0;
      out_r   <= '0;
      flags_r <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_r <= s_res;
            e1_r   <= ea;
            e2_r   <= eb;
            mc     <= {{SIG_W{1'b0}}, 1'b1, fa};
            mb     <= {1'b1, fb};
            acc    <= '0;
            cnt    <= '0;
            if (spec_hit) begin
              out_r   <= spec_out;
              flags_r <= spec_flags;
              state   <= DONE;
            end else begin
              state <= MUL;
            end
          end
        end
        MUL: begin
          acc <= pp_sum;
          mc  <= mc << BPC;
          mb  <= mb >> BPC;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(N - 1)) state <= NORM;
        end
        NORM: begin
          out_r   <= rn_result;
          flags_r <= rn_flags;
          state   <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out       = out_r;
  assign flags     = flags_r;
  assign dbg_state = state;

endmodule

// File: tb/tb_fp_mul_seq.sv
module tb_fp_mul_seq;
  import fp_mul_pkg::*;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        out_ready;
  logic [31:0] in1, in2;
  logic [2:0]  in_valid_v;
  logic [2:0]  in_ready_v;
  logic [2:0]  out_valid_v;
  logic [31:0] out_v   [3];
  logic [3:0]  flags_v [3];
  state_t      dbg_v   [3];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  fp_mul_seq #(.EXP_W(8), .FRAC_W(23), .BPC(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .in1(in1), .in2(in2), .out_valid(out_valid_v[0]), .out_ready(out_ready),
    .out(out_v[0]), .flags(flags_v[0]), .dbg_state(dbg_v[0])
  );

  fp_mul_seq #(.EXP_W(8), .FRAC_W(23), .BPC(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .in1(in1), .in2(in2), .out_valid(out_valid_v[1]), .out_ready(out_ready),
    .out(out_v[1]), .flags(flags_v[1]), .dbg_state(dbg_v[1])
  );

  fp_mul_seq #(.EXP_W(8), .FRAC_W(23), .BPC(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .in1(in1), .in2(in2), .out_valid(out_valid_v[2]), .out_ready(out_ready),
    .out(out_v[2]), .flags(flags_v[2]), .dbg_state(dbg_v[2])
  );

  // Scoreboard comparison
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver: present operands for one accept, then wait (bounded) for out_valid.
  // Returns in the first cycle out_valid is seen; latency counts from accept.
  task automatic run_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_out, input logic [3:0] exp_fl,
                        input int exp_lat, input string tag);
    int lat;
    bit busy_ok;
    chk({tag, " in_ready before accept"}, in_ready_v[sel], 1);
    in1 = a;
    in2 = b;
    in_valid_v[sel] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[sel] = 1'b0;
    lat = 1;
    busy_ok = 1'b1;
    while (out_valid_v[sel] !== 1'b1 && lat < 200) begin
      if (in_ready_v[sel] !== 1'b0) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (in_ready_v[sel] !== 1'b0) busy_ok = 1'b0;
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " out"}, out_v[sel], exp_out);
    chk({tag, " flags"}, flags_v[sel], exp_fl);
    chk({tag, " in_ready low while busy"}, busy_ok, 1);
  endtask

  // Complete the output handshake and check the return to IDLE.
  task automatic release_out(input int sel, input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, " out_valid dropped"}, out_valid_v[sel], 0);
    chk({tag, " in_ready back"}, in_ready_v[sel], 1);
  endtask

  initial begin
    bit stable_ok;
    bit no_out;

    rst        = 1'b1;
    out_ready  = 1'b1;
    in_valid_v = 3'b000;
    in1        = '0;
    in2        = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", in_ready_v[0], 1);
    chk("reset out_valid", out_valid_v[0], 0);
    chk("reset out", out_v[0], 0);
    chk("reset flags", flags_v[0], 0);
    chk("reset state", dbg_v[0], IDLE);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1.5 * 2.0 = 3.0
    run_op(0, 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 26, "t1");
    release_out(0, "t1");

    // Rounding: tie with even LSB stays, sticky-only stays, tie with odd LSB
    // rounds up, and all-ones fraction rounding carries into the exponent.
    run_op(0, 32'h3F800800, 32'h3F800800, 32'h3F801000, 4'b0001, 26, "t2 tie even");
    release_out(0, "t2a");
    run_op(0, 32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, 26, "t2 sticky");
    release_out(0, "t2b");
    run_op(0, 32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001, 26, "t2 tie odd");
    release_out(0, "t2c");
    run_op(0, 32'h3FFFFFFE, 32'h3F800001, 32'h40000000, 4'b0001, 26, "t2 carry");
    release_out(0, "t2d");

    // Range limits
    run_op(0, 32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101, 26, "t3 overflow");
    release_out(0, "t3a");
    run_op(0, 32'h80800000, 32'h3F000000, 32'h80000000, 4'b0011, 26, "t3 underflow");
    release_out(0, "t3b");

    // Special operands take the short path
    run_op(0, 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, 1, "t4 inf*0");
    release_out(0, "t4a");
    run_op(0, 32'h7FA00000, 32'h3F800000, 32'h7FC00000, 4'b1000, 1, "t4 snan");
    release_out(0, "t4b");
    run_op(0, 32'h007FFFFF, 32'h40000000, 32'h00000000, 4'b0000, 1, "t4 subnormal");
    release_out(0, "t4c");
    run_op(0, 32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 1, "t4 inf*2");
    release_out(0, "t4d");
    run_op(0, 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b0000, 1, "t4 qnan");
    release_out(0, "t4e");

    // Backpressure: 3.0 * 3.0 = 9.0 held in DONE while in_valid toggles on.
    out_ready = 1'b0;
    run_op(0, 32'h40400000, 32'h40400000, 32'h41100000, 4'b0000, 26, "t5");
    in1 = 32'h3F800000;
    in2 = 32'h3F800000;
    in_valid_v[0] = 1'b1;
    stable_ok = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (out_v[0] !== 32'h41100000 || flags_v[0] !== 4'b0000 ||
          in_ready_v[0] !== 1'b0 || out_valid_v[0] !== 1'b1) stable_ok = 1'b0;
    end
    chk("t5 held stable under backpressure", stable_ok, 1);
    in_valid_v[0] = 1'b0;
    release_out(0, "t5");
    // Back-to-back: 2.0 * 2.0 = 4.0 accepted on the first IDLE cycle
    run_op(0, 32'h40000000, 32'h40000000, 32'h40800000, 4'b0000, 26, "t5 b2b");
    release_out(0, "t5b");

    // Reset in the middle of MUL aborts the operation.
    in1 = 32'h3FC00000;
    in2 = 32'h40000000;
    in_valid_v[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    chk("t6 in MUL at cycle 10", dbg_v[0], MUL);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t6 reset out_valid", out_valid_v[0], 0);
    chk("t6 reset in_ready", in_ready_v[0], 1);
    chk("t6 reset out", out_v[0], 0);
    chk("t6 reset flags", flags_v[0], 0);
    no_out = 1'b1;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid_v[0] !== 1'b0) no_out = 1'b0;
    end
    chk("t6 no output for aborted op", no_out, 1);
    run_op(0, 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 26, "t6 after reset");
    release_out(0, "t6");

    // Wider digit per cycle
    run_op(1, 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 8, "t6 bpc4");
    release_out(1, "t6 bpc4");
    run_op(2, 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 5, "t6 bpc8");
    release_out(2, "t6 bpc8");
    run_op(1, 32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001, 8, "t6 bpc4 round");
    release_out(1, "t6 bpc4 round");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
